// File: rtl/instr_fetch_if.sv
// Bundle between the fetch unit, instruction memory and decode.
//
// Handshakes:
//   imem: the master raises imem_req with imem_addr and holds both steady
//         until a cycle with imem_ack=1. imem_data is sampled in that cycle.
//         imem_ack is ignored while imem_req=0. At most one request is
//         outstanding. A reset may drop imem_req without an ack.
//   out : out_instr/out_pc/out_pc_inc are the queue head while out_valid=1.
//         The head is consumed on a rising edge with out_valid & out_ready.
//         All three read as zero while out_valid=0.
//   redirect is a one-cycle pulse that restarts fetch at redirect_pc.
// dbg_state exposes the fetch FSM state for checkers.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_inc;
  logic              misalign;
  logic [1:0]        dbg_state;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc, out_pc_inc, misalign, dbg_state
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc, out_pc_inc, misalign, dbg_state
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the PC, issues single outstanding word
// requests, buffers returned words in a DEPTH-entry queue for decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises a
// sticky misalign flag and halts fetch until reset or an aligned redirect.
// Without it, redirect targets are forced word aligned and misalign is 0.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ST_IDLE: no request; ST_REQ: request live, ack data is kept;
  // ST_DISCARD: request live but a redirect arrived, its ack is dropped.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              trap_q, trap_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];

  logic              ack, pop, push, head_valid;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt    = bus.redirect_pc;
  assign redir_bad    = |bus.redirect_pc[1:0];
  assign bus.misalign = trap_q;
`else
  assign redir_tgt    = bus.redirect_pc & ~ADDR_W'(3);
  assign redir_bad    = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  assign ack        = (state_q != ST_IDLE) & bus.imem_ack;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.out_ready;

  assign bus.imem_req   = (state_q != ST_IDLE);
  assign bus.imem_addr  = addr_q;
  assign bus.out_valid  = head_valid;
  assign bus.out_instr  = head_valid ? instr_mem_q[rd_q] : '0;
  assign bus.out_pc     = head_valid ? pc_mem_q[rd_q] : '0;
  assign bus.out_pc_inc = head_valid ? pc_mem_q[rd_q] + ADDR_W'(4) : '0;
  assign bus.dbg_state  = state_q;

  // Next-state: redirect first, then discard drain, then normal push/pop/issue.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;
    trap_d      = trap_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    push        = 1'b0;
    if (bus.redirect) begin
      // Flush wins over any same-cycle push or pop.
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      fetch_pc_d = redir_tgt;
      trap_d     = redir_bad;
      if ((state_q != ST_IDLE) && !ack) begin
        // Keep req/addr steady; the stale ack is dropped when it arrives.
        state_d = ST_DISCARD;
      end else begin
        state_d = redir_bad ? ST_IDLE : ST_REQ;
        addr_d  = redir_tgt;
      end
    end else if (state_q == ST_DISCARD) begin
      if (ack) begin
        state_d = trap_q ? ST_IDLE : ST_REQ;
        addr_d  = fetch_pc_q;
      end
    end else begin
      push = ack;
      if (push) begin
        pc_mem_d[wr_q]    = addr_q;
        instr_mem_d[wr_q] = bus.imem_data;
        wr_d              = wr_q + PTR_W'(1);
        fetch_pc_d        = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // A new request needs a free slot after this cycle's push and pop.
      if ((state_q == ST_IDLE) || push) begin
        state_d = ((count_d < CNT_W'(DEPTH)) && !trap_q) ? ST_REQ : ST_IDLE;
        addr_d  = fetch_pc_d;
      end
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      trap_q     <= trap_d;
    end
  end

  // Queue storage; head outputs are masked while empty, so no reset needed.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for streaming and full-queue
// behaviour, then hand sequences for redirect corners, address wrap and the
// misaligned-redirect handling of the current build.
module tb_instr_fetch;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW)) bus ();
  instr_fetch_if #(.ADDR_W(8))  bus8 ();

  instr_fetch #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  instr_fetch #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h0)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- memory model (variable latency) ----------------
  int mem_lat  = 0;
  int wait_cnt = 0;
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forever begin
      @(negedge clk);
      if (reset || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end else if (wait_cnt >= mem_lat) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem_word(bus.imem_addr);
        wait_cnt      = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  bit sb_on = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb_on && bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        check("sb_pc", bus.out_pc, e);
        check("sb_instr", bus.out_instr, mem_word(e));
        check("sb_pc_inc", bus.out_pc_inc, e + 32'd4);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    int n;
    logic [31:0] e_instr, e_inc;

    // Streaming with 0-wait memory and out_ready=1, then a full queue with out_ready=0.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h04};

    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.out_ready    = 1'b0;
    bus8.imem_ack    = 1'b0;
    bus8.imem_data   = '0;
    bus8.redirect    = 1'b0;
    bus8.redirect_pc = '0;
    bus8.out_ready   = 1'b0;

    // Reset values of the byte-address instance.
    #2;
    check("rst8_req", 32'(bus8.imem_req), 32'h0);
    check("rst8_pc_inc", 32'(bus8.out_pc_inc), 32'h0);
    check("rst_misalign", 32'(bus.misalign), 32'h0);

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      #1;
      reset         = vecs[i].rst;
      bus.out_ready = vecs[i].ready;
      #1;
      e_instr = vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0;
      e_inc   = vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'h0;
      check($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), bus.out_instr, e_instr);
      check($sformatf("vec%0d_pc_inc", i), bus.out_pc_inc, e_inc);
    end

    // ---- 3-cycle memory, redirect while the request to 0x8 is outstanding ----
    mem_lat       = 3;
    bus.out_ready = 1'b1;
    do_reset();
    exp_q = {32'h0, 32'h4, 32'h40, 32'h44};
    sb_on = 1'b1;
    for (n = 0; n < 50 && !(bus.imem_req && bus.imem_addr == 32'h8); n++) tick();
    check("c_req8_seen", 32'(n < 50), 32'h1);
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    for (n = 0; n < 10; n++) begin
      check("c_hold_req", 32'(bus.imem_req), 32'h1);
      check("c_hold_addr", bus.imem_addr, 32'h8);
      check("c_flushed", 32'(bus.out_valid), 32'h0);
      if (bus.imem_ack) break;
      tick();
    end
    check("c_ack_seen", 32'(n < 10), 32'h1);
    tick();
    check("c_new_req", 32'(bus.imem_req), 32'h1);
    check("c_new_addr", bus.imem_addr, 32'h40);
    for (n = 0; n < 60 && exp_q.size() > 0; n++) tick();
    check("c_drain", 32'(exp_q.size()), 32'h0);
    sb_on         = 1'b0;
    bus.out_ready = 1'b0;

    // ---- redirect coincident with ack and pop, two entries queued ----
    mem_lat = 0;
    do_reset();
    tick();
    tick();
    tick();
    check("d_valid", 32'(bus.out_valid), 32'h1);
    check("d_head", bus.out_pc, 32'h0);
    check("d_req_addr", bus.imem_addr, 32'h8);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    bus.out_ready   = 1'b1;
    tick();
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b0;
    check("d_flush", 32'(bus.out_valid), 32'h0);
    check("d_req", 32'(bus.imem_req), 32'h1);
    check("d_addr", bus.imem_addr, 32'h100);
    tick();
    check("d_valid2", 32'(bus.out_valid), 32'h1);
    check("d_pc2", bus.out_pc, 32'h100);
    check("d_instr2", bus.out_instr, mem_word(32'h100));

    // ---- misaligned redirect to 0x22 ----
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h22;
    tick();
    bus.redirect = 1'b0;
    check("f_flush", 32'(bus.out_valid), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("f_trap", 32'(bus.misalign), 32'h1);
    check("f_stop", 32'(bus.imem_req), 32'h0);
    tick();
    tick();
    check("f_trap_sticky", 32'(bus.misalign), 32'h1);
    check("f_still_stop", 32'(bus.imem_req), 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h24;
    tick();
    bus.redirect = 1'b0;
    check("f_clear", 32'(bus.misalign), 32'h0);
    check("f_resume", 32'(bus.imem_req), 32'h1);
    check("f_addr", bus.imem_addr, 32'h24);
`else
    check("f_no_trap", 32'(bus.misalign), 32'h0);
    check("f_req", 32'(bus.imem_req), 32'h1);
    check("f_aligned_addr", bus.imem_addr, 32'h20);
`endif

    // ---- 8-bit address wrap on the second instance ----
    check("e_pending", 32'(bus8.imem_req), 32'h1);
    bus8.redirect    = 1'b1;
    bus8.redirect_pc = 8'hFC;
    bus8.imem_ack    = 1'b1;
    bus8.imem_data   = 32'hDEAD_0000;
    tick();
    bus8.redirect = 1'b0;
    bus8.imem_ack = 1'b0;
    check("e_req", 32'(bus8.imem_req), 32'h1);
    check("e_addr_fc", 32'(bus8.imem_addr), 32'hFC);
    check("e_dropped", 32'(bus8.out_valid), 32'h0);
    bus8.imem_ack  = 1'b1;
    bus8.imem_data = 32'h1111_2222;
    tick();
    bus8.imem_ack = 1'b0;
    check("e_addr_wrap", 32'(bus8.imem_addr), 32'h00);
    check("e_valid", 32'(bus8.out_valid), 32'h1);
    check("e_pc", 32'(bus8.out_pc), 32'hFC);
    check("e_pc_inc_wrap", 32'(bus8.out_pc_inc), 32'h00);
    check("e_instr", bus8.out_instr, 32'h1111_2222);

    // ---- report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Parametrised instruction-fetch front end for the next-generation MIPS-subset core. It owns the program counter and issues one-at-a-time word requests to a variable-latency instruction memory. Returned instructions are buffered in a DEPTH-entry queue and handed to decode over a valid/ready interface. Redirects from jump, jr and bne resolution flush the queue and restart fetch.

## Interface
- ADDR_W, 32, program-counter and memory address width (≥ 3).
- DEPTH, 4, instruction queue entries (power of two, ≥ 2).
- RESET_PC, 0, first fetch address after reset (word aligned).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1.
- imem_ack  in  1  response strobe; data valid this cycle; ignored when imem_req=0.
- imem_data  in  32  instruction word.
- redirect  in  1  one-cycle pulse; restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  address of head instruction.
- out_pc_inc  out  ADDR_W  out_pc+4 modulo 2^ADDR_W (link/bne base).
- misalign  out  1  misaligned-redirect trap (see Configuration).

## Operation
- Registers: fetch_pc, imem_req, discard flag, queue (pc, instr) entries, read/write pointers, occupancy count 0..DEPTH.
- Issue rule: imem_req rises only when occupancy_next + 1 ≤ DEPTH. occupancy_next includes this cycle's push and pop. At most one request is outstanding.
- On accepted ack with discard=0: push {imem_addr, imem_data}; fetch_pc ← fetch_pc+4, wrapping modulo 2^ADDR_W. imem_req stays 1 with the new address if credit allows, else drops to 0.
- Pop when out_valid & out_ready. Push and pop in the same cycle leave occupancy unchanged. A push into an empty queue is not bypassed.
- Redirect: queue emptied next cycle (out_valid=0), fetch_pc ← redirect_pc.
  - No request outstanding, or ack in the same cycle: the ack data is dropped; the next cycle issues a request to redirect_pc.
  - Request outstanding without ack: imem_req/imem_addr are held unchanged (handshake stability) and discard ← 1. The matching ack is dropped and clears discard. The following cycle issues redirect_pc.
  - A second redirect while discard=1 only updates fetch_pc.
- Redirect takes priority over a simultaneous pop or push.
- reset mid-transaction abandons any outstanding request. Memory must tolerate req falling without ack.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, occupancy=0, out_valid=0, out_instr=0, out_pc=0, out_pc_inc=0 (undefined-free), discard=0, misalign=0.
- First imem_req=1 in the first clk edge after reset deasserts.
- Ack at edge N → out_valid=1 after edge N (visible cycle N+1) when the queue was empty.
- Redirect at edge N with idle memory → imem_req=1, imem_addr=redirect_pc in cycle N+1.
- Sustained throughput is 1 instr/cycle with a zero-wait-state memory and out_ready=1.
- Full queue (occupancy=DEPTH) → imem_req=0. It reasserts in the cycle after the first pop.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets misalign=1 (sticky), flushes the queue and stops issuing.
  - Only reset or an aligned redirect clears it and resumes fetch.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - misalign is tied 0.

## Test plan
- Reset release, 0-wait memory, out_ready=1 → addresses 0,4,8,… on consecutive cycles; first out_valid one cycle after first ack; out_pc_inc=out_pc+4.
- DEPTH=4, out_ready=0 → exactly 4 acks accepted, then imem_req=0; one pop → req reasserts with addr 0x10 the next cycle.
- 3-cycle memory latency, redirect to 0x40 one cycle after request to 0x8 → imem_addr stays 0x8 until ack; that data never appears; next request is 0x40; first out_pc=0x40.
- Redirect to 0x100 coincident with ack and pop, queue holding 2 entries → out_valid=0 next cycle; next imem_addr=0x100.
- ADDR_W=8, redirect to 0xFC → fetches 0xFC then 0x00 (wrap).
- FETCH_MISALIGN_TRAP_EN, redirect to 0x22 → misalign=1, imem_req stays 0; redirect to 0x24 → misalign=0, fetch at 0x24.
